// File: rtl/hnf_slc_arb_pkg.sv
// hnf_slc_arb_pkg: flit payload types and widths shared by the SLC lookup-port
// arbiter, its interface and its testbench.
package hnf_slc_arb_pkg;

  localparam int unsigned TXN_W     = 8;
  localparam int unsigned REQ_OP_W  = 6;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned RSP_OP_W  = 4;
  localparam int unsigned RESP_W    = 3;
  localparam int unsigned STARVE_W  = 4;

  // RXREQ flit as seen by the SLC lookup port
  typedef struct packed {
    logic [TXN_W-1:0]    txn_id;
    logic [REQ_OP_W-1:0] opcode;
    logic [ADDR_W-1:0]   addr;
  } reqflit_t;

  // RXRSP flit as seen by the SLC lookup port
  typedef struct packed {
    logic [TXN_W-1:0]    txn_id;
    logic [RSP_OP_W-1:0] opcode;
    logic [RESP_W-1:0]   resp;
  } rspflit_t;

endpackage

// File: rtl/hnf_slc_arb_if.sv
// hnf_slc_arb_if: bundles the RXREQ/RXRSP input handshakes, the quiesce
// control and the SLC output handshake.
//   master : pipe/SLC side (drives valids, flits, quiesce, slc_ready)
//   slave  : arbiter side (drives readys, held flit, arb_idle)
interface hnf_slc_arb_if;
  import hnf_slc_arb_pkg::*;

  logic     req_valid;
  logic     req_ready;
  reqflit_t req_flit;
  logic     rsp_valid;
  logic     rsp_ready;
  rspflit_t rsp_flit;
  logic     quiesce;
  logic     slc_valid;
  logic     slc_ready;
  logic     slc_is_rsp;
  reqflit_t slc_req;
  rspflit_t slc_rsp;
  logic     arb_idle;

  modport master (
    output req_valid, req_flit, rsp_valid, rsp_flit, quiesce, slc_ready,
    input  req_ready, rsp_ready, slc_valid, slc_is_rsp, slc_req, slc_rsp, arb_idle
  );

  modport slave (
    input  req_valid, req_flit, rsp_valid, rsp_flit, quiesce, slc_ready,
    output req_ready, rsp_ready, slc_valid, slc_is_rsp, slc_req, slc_rsp, arb_idle
  );

endinterface

// File: rtl/hnf_slc_arb.sv
// hnf_slc_arb: shares the single SLC/snoop-filter lookup port between the
// RXRSP and RXREQ pipes. Responses win by default; a saturating starvation
// counter lets a waiting request through after STARVE_MAX response wins.
// The winner sits in a one-entry output register with a valid/ready handshake.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   bus        hnf_slc_arb_if.slave (input handshakes, quiesce, SLC output)
module hnf_slc_arb
  import hnf_slc_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  hnf_slc_arb_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                load_c;
  logic                grant_rsp_c;
  logic                grant_req_c;

  logic     slc_valid_q;
  logic     slc_is_rsp_q;
  reqflit_t slc_req_q;
  rspflit_t slc_rsp_q;

  // Grant decision: register must be free or draining this cycle
  always_comb begin
    load_c      = ~reset & ~bus.quiesce & (~slc_valid_q | bus.slc_ready);
    grant_rsp_c = load_c & bus.rsp_valid & (~bus.req_valid | (starve_cnt < STARVE_LIM));
    grant_req_c = load_c & bus.req_valid & ~grant_rsp_c;
  end

  assign bus.rsp_ready  = grant_rsp_c;
  assign bus.req_ready  = grant_req_c;
  assign bus.slc_valid  = slc_valid_q;
  assign bus.slc_is_rsp = slc_is_rsp_q;
  assign bus.slc_req    = slc_req_q;
  assign bus.slc_rsp    = slc_rsp_q;
  assign bus.arb_idle   = ~slc_valid_q & ~bus.req_valid & ~bus.rsp_valid;

  // One-entry output register; a held flit drains on slc_ready even under quiesce
  always_ff @(posedge clock) begin
    if (reset) begin
      slc_valid_q  <= 1'b0;
      slc_is_rsp_q <= 1'b0;
      slc_req_q    <= '0;
      slc_rsp_q    <= '0;
    end else if (grant_rsp_c) begin
      slc_valid_q  <= 1'b1;
      slc_is_rsp_q <= 1'b1;
      slc_req_q    <= '0;
      slc_rsp_q    <= bus.rsp_flit;
    end else if (grant_req_c) begin
      slc_valid_q  <= 1'b1;
      slc_is_rsp_q <= 1'b0;
      slc_req_q    <= bus.req_flit;
      slc_rsp_q    <= '0;
    end else if (bus.slc_ready) begin
      slc_valid_q  <= 1'b0;
    end
  end

  // Starvation counter: counts response wins taken while a request waits
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (~bus.req_valid | grant_req_c) begin
      starve_cnt <= '0;
    end else if (grant_rsp_c && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: tb/tb_hnf_slc_arb.sv
// tb_hnf_slc_arb: table-driven vectors, hand sequences and randomized
// stimulus for hnf_slc_arb, checked against a behavioural reference model.
module tb_hnf_slc_arb;
  import hnf_slc_arb_pkg::*;

  localparam int unsigned SM = 4;

  logic clock = 1'b0;
  logic reset;
  logic reset0;
  always #5 clock = ~clock;

  hnf_slc_arb_if bus4();
  hnf_slc_arb_if bus0();

  hnf_slc_arb #(.STARVE_MAX(SM)) u_dut4 (.clock(clock), .reset(reset),  .bus(bus4));
  hnf_slc_arb #(.STARVE_MAX(0))  u_dut0 (.clock(clock), .reset(reset0), .bus(bus0));

  int total = 0;
  int bad   = 0;

  // reference model state: what the output slot holds and the streak of
  // response wins a waiting request has already sat through
  bit       m_valid  = 1'b0;
  bit       m_is_rsp = 1'b0;
  reqflit_t m_req    = '0;
  rspflit_t m_rsp    = '0;
  int       m_streak = 0;

  bit g_req, g_rsp;

  typedef struct {
    bit rst, qv, sv, q, sr;
    bit e_rq, e_rs, e_v, e_isr;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus on the STARVE_MAX=4 instance, checked against the model
  task automatic step(input bit rst, input bit qv, input bit sv, input bit q, input bit sr);
    reqflit_t qf;
    rspflit_t sf;
    bit take, rw, qw, idle;
    @(negedge clock);
    qf.txn_id = TXN_W'($urandom);
    qf.opcode = REQ_OP_W'($urandom);
    qf.addr   = ADDR_W'($urandom);
    sf.txn_id = TXN_W'($urandom);
    sf.opcode = RSP_OP_W'($urandom);
    sf.resp   = RESP_W'($urandom);
    reset          = rst;
    bus4.req_valid = qv;
    bus4.req_flit  = qf;
    bus4.rsp_valid = sv;
    bus4.rsp_flit  = sf;
    bus4.quiesce   = q;
    bus4.slc_ready = sr;
    #1;
    take = !rst && !q && (!m_valid || sr);
    rw   = take && sv && (!qv || m_streak < int'(SM));
    qw   = take && qv && !rw;
    idle = !m_valid && !qv && !sv;
    check("req_ready",  64'(bus4.req_ready),  64'(qw));
    check("rsp_ready",  64'(bus4.rsp_ready),  64'(rw));
    check("slc_valid",  64'(bus4.slc_valid),  64'(m_valid));
    check("slc_is_rsp", 64'(bus4.slc_is_rsp), 64'(m_is_rsp));
    check("slc_req",    64'(bus4.slc_req),    64'(m_req));
    check("slc_rsp",    64'(bus4.slc_rsp),    64'(m_rsp));
    check("arb_idle",   64'(bus4.arb_idle),   64'(idle));
    g_req = bus4.req_ready;
    g_rsp = bus4.rsp_ready;
    // advance model to what the coming edge should produce
    if (rst) begin
      m_valid = 0; m_is_rsp = 0; m_req = '0; m_rsp = '0; m_streak = 0;
    end else begin
      if (rw) begin
        m_valid = 1; m_is_rsp = 1; m_rsp = sf; m_req = '0;
      end else if (qw) begin
        m_valid = 1; m_is_rsp = 0; m_req = qf; m_rsp = '0;
      end else if (sr) begin
        m_valid = 0;
      end
      if (!qv || qw) m_streak = 0;
      else if (rw && m_streak < int'(SM)) m_streak++;
    end
  endtask

  initial begin
    int nq, nr, nb, cnt;
    bit seen;
    reset = 1'b1;  reset0 = 1'b1;
    bus4.req_valid = 0; bus4.rsp_valid = 0; bus4.quiesce = 0; bus4.slc_ready = 0;
    bus4.req_flit = '0; bus4.rsp_flit = '0;
    bus0.req_valid = 0; bus0.rsp_valid = 0; bus0.quiesce = 0; bus0.slc_ready = 0;
    bus0.req_flit = '0; bus0.rsp_flit = '0;

    // reset with both valid, release, starvation pattern, backpressure
    tbl[0]  = '{1,1,1,0,1, 0,0,0,0};
    tbl[1]  = '{1,1,1,0,1, 0,0,0,0};
    tbl[2]  = '{0,1,1,0,1, 0,1,0,0};
    tbl[3]  = '{0,1,1,0,1, 0,1,1,1};
    tbl[4]  = '{0,1,1,0,1, 0,1,1,1};
    tbl[5]  = '{0,1,1,0,1, 0,1,1,1};
    tbl[6]  = '{0,1,1,0,1, 1,0,1,1};
    tbl[7]  = '{0,1,1,0,1, 0,1,1,0};
    tbl[8]  = '{0,1,1,0,1, 0,1,1,1};
    tbl[9]  = '{0,1,1,0,1, 0,1,1,1};
    tbl[10] = '{0,1,1,0,1, 0,1,1,1};
    tbl[11] = '{0,1,1,0,1, 1,0,1,1};
    tbl[12] = '{0,0,1,0,0, 0,0,1,0};
    tbl[13] = '{0,0,1,0,0, 0,0,1,0};
    tbl[14] = '{0,0,1,0,0, 0,0,1,0};
    tbl[15] = '{0,0,1,0,1, 0,1,1,0};
    tbl[16] = '{0,0,0,0,1, 0,0,1,1};
    tbl[17] = '{0,0,0,0,1, 0,0,0,1};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].qv, tbl[i].sv, tbl[i].q, tbl[i].sr);
      check($sformatf("tbl%0d_req_ready", i),  64'(g_req),           64'(tbl[i].e_rq));
      check($sformatf("tbl%0d_rsp_ready", i),  64'(g_rsp),           64'(tbl[i].e_rs));
      check($sformatf("tbl%0d_slc_valid", i),  64'(bus4.slc_valid),  64'(tbl[i].e_v));
      check($sformatf("tbl%0d_slc_is_rsp", i), 64'(bus4.slc_is_rsp), 64'(tbl[i].e_isr));
    end

    // quiesce: held flit drains, no new grants, idle only once inputs drop
    step(0,1,0,0,1);
    check("q_grant_req", 64'(g_req), 64'(1));
    step(0,1,1,1,0);
    step(0,1,1,1,1);
    check("q_drain_no_grant", 64'({g_req, g_rsp}), 64'(0));
    step(0,1,1,1,1);
    check("q_drained_valid", 64'(bus4.slc_valid), 64'(0));
    check("q_idle_busy", 64'(bus4.arb_idle), 64'(0));
    step(0,0,0,1,1);
    check("q_idle", 64'(bus4.arb_idle), 64'(1));
    step(0,0,0,0,1);

    // fairness: 20 cycles both valid -> R,R,R,R,Q repeating, no bubbles
    step(1,0,0,0,1);
    nq = 0; nr = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(0,1,1,0,1);
      check($sformatf("fair%0d_rsp", i), 64'(g_rsp), 64'((i % 5) != 4));
      if (g_req) nq++;
      if (g_rsp) nr++;
      if (!g_req && !g_rsp) nb++;
    end
    check("fair_req_grants", 64'(nq), 64'(4));
    check("fair_rsp_grants", 64'(nr), 64'(16));
    check("fair_bubbles",    64'(nb), 64'(0));

    // counter clears when req_valid drops
    step(1,0,0,0,1);
    for (int i = 0; i < 3; i++) step(0,1,1,0,1);
    step(0,0,1,0,1);
    cnt = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0,1,1,0,1);
      if (g_req) seen = 1;
      else if (g_rsp) cnt++;
    end
    check("clr_req_seen", 64'(seen), 64'(1));
    check("clr_rsp_wins", 64'(cnt), 64'(4));

    // reset while a flit is held discards it
    step(0,0,0,0,0);
    check("hold_valid", 64'(bus4.slc_valid), 64'(1));
    step(1,0,0,0,0);
    step(0,0,0,0,0);
    check("rst_mid_hold", 64'(bus4.slc_valid), 64'(0));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0,63) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0,7) == 0), ($urandom_range(0,3) != 0));
    end

    // STARVE_MAX=0: requests have strict priority
    @(negedge clock);
    reset0 = 1'b0;
    bus0.req_valid = 1; bus0.rsp_valid = 1; bus0.slc_ready = 1;
    bus0.req_flit = '0; bus0.rsp_flit = '0;
    #1;
    check("sm0_reset_valid", 64'(bus0.slc_valid), 64'(0));
    nq = 0; nr = 0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        @(negedge clock);
        #1;
      end
      if (bus0.req_ready) nq++;
      if (bus0.rsp_ready) nr++;
    end
    check("sm0_req_grants", 64'(nq), 64'(5));
    check("sm0_rsp_grants", 64'(nr), 64'(0));
    @(negedge clock);
    #1;
    check("sm0_held_is_req", 64'({bus0.slc_valid, bus0.slc_is_rsp}), 64'(2'b10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hnf_slc_arb.md
# hnf_slc_arb

Arbiter sharing the single SLC/snoop-filter lookup port between the HN-F RXRSP and RXREQ pipes. Responses get priority because they retire POCQ entries and must not back up behind new requests. A saturating starvation counter guarantees forward progress for requests. The winner is captured in a one-entry output register that drives the SLC with a valid/ready handshake. A quiesce input lets the top level stop new grants and drain the port.

## Interface
- `STARVE_MAX`, default 4: consecutive response wins allowed while a request is waiting. Legal range 0..15; 0 gives requests strict priority.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  RXREQ pipe has a flit.
- `req_ready`  out  1  request accepted this cycle.
- `req_flit`  in  `reqflit_t`  request flit.
- `rsp_valid`  in  1  RXRSP pipe has a flit.
- `rsp_ready`  out  1  response accepted this cycle.
- `rsp_flit`  in  `rspflit_t`  response flit.
- `quiesce`  in  1  block new grants while high.
- `slc_valid`  out  1  output register holds a flit for the SLC.
- `slc_ready`  in  1  SLC accepts the held flit.
- `slc_is_rsp`  out  1  held flit is a response (1) or a request (0).
- `slc_req`  out  `reqflit_t`  held request; `'0` when `slc_is_rsp`=1.
- `slc_rsp`  out  `rspflit_t`  held response; `'0` when `slc_is_rsp`=0.
- `arb_idle`  out  1  `~slc_valid & ~req_valid & ~rsp_valid`.

## Operation
- `load = ~reset & ~quiesce & (~slc_valid | slc_ready)`.
- `grant_rsp = load & rsp_valid & (~req_valid | starve_cnt < STARVE_MAX)`.
- `grant_req = load & req_valid & ~grant_rsp`.
- `rsp_ready = grant_rsp`; `req_ready = grant_req`. At most one is high per cycle.
- Readys depend on the valids of both channels. Valids must not depend on readys.
- On a grant, the output register loads the winning flit and `slc_is_rsp`, zeroes the other flit field, and sets `slc_valid`=1.
- If `load` is high with no grant and `slc_ready`=1, `slc_valid` clears.
- `starve_cnt` is internal, width 4:
  - cleared when `req_valid`=0 or on `grant_req`;
  - +1 (saturating at `STARVE_MAX`) on `grant_rsp` while `req_valid`=1;
  - otherwise holds.
- Held flit rule: while `slc_valid & ~slc_ready`, all outputs stay stable and both readys are 0.
- `quiesce` blocks new grants only. A flit already held still completes on `slc_ready`.
- Reset mid-hold: the held flit is discarded; `slc_valid`=0 after the reset edge.
- Reset values: `slc_valid`=0, `slc_is_rsp`=0, `slc_req`=`'0`, `slc_rsp`=`'0`, `starve_cnt`=0. Readys are 0 during reset.

## Timing
- Latency is 1 cycle: a grant in cycle N gives `slc_valid`=1 in cycle N+1.
- Throughput is 1 flit/cycle. The drain and the next grant happen in the same cycle when `slc_ready`=1.
- With both channels valid and `slc_ready`=1, the grant pattern is `STARVE_MAX` responses then 1 request, repeating (period `STARVE_MAX`+1).
- Flits must not be accepted without a matching ready. Input flits are sampled only on the grant edge.

## Structure
- Flit typedefs `reqflit_t` and `rspflit_t` come from `chi_flit.vh`.
- Add `HNF_SLC_ARB_STARVE_MAX` (default 4) to `autoconfig.vh`; `SHCache` passes it to `STARVE_MAX`.
- Single module, no sub-module. The output register and counter are small enough to keep inline.
- Replaces the shared-ready TODO on the `rxreq_slc`/`rxrsp_slc` pout side in `SHCache`.

## Test plan
- Reset: hold `reset` 2 cycles with `req_valid`=`rsp_valid`=1 → `slc_valid`=0 and readys 0 throughout. First cycle after release: `rsp_ready`=1, then `slc_valid`=1 with `slc_is_rsp`=1 the next cycle.
- Fairness: `STARVE_MAX`=4, both valid, `slc_ready`=1 for 20 cycles → grant sequence R,R,R,R,Q repeating, 4 Q grants total, no bubbles.
- Backpressure: grant a request, then hold `slc_ready`=0 for 3 cycles → `slc_req` stable, readys 0. When `slc_ready`=1 returns, a pending response is granted in the same cycle.
- Quiesce: `quiesce`=1 while a flit is held, then `slc_ready`=1 → held flit drains, no new grants, `arb_idle`=0 while inputs are valid. Drop the inputs → `arb_idle`=1.
- Strict request priority: `STARVE_MAX`=0, both valid for 5 cycles → 5 request grants, 0 response grants.
- Counter clear and reset mid-hold: 3 response wins, then `req_valid`=0 for 1 cycle, then both valid → 4 more response wins before the request. Assert `reset` while `slc_valid`=1 and `slc_ready`=0 → `slc_valid`=0 on the next cycle.
